// File: rtl/sim_memory_controller_pkg.sv
// Shared packet geometry, default sizing and FSM encoding for the behavioural main-memory model.
package sim_memory_controller_pkg;

    localparam int UNIFIED_CACHE_BLOCK_SIZE_IN_BITS       = 64;
    localparam int UNIFIED_CACHE_BLOCK_OFFSET_LEN_IN_BITS = $clog2(UNIFIED_CACHE_BLOCK_SIZE_IN_BITS / 8);
    localparam int CPU_ADDR_LEN_IN_BITS                   = 32;
    localparam int PACKET_TYPE_LEN                        = 2;
    localparam int PACKET_PORT_LEN                        = 2;

    // Packet layout, LSB first: data | addr | byte_mask | type | port | is_write | valid
    localparam int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS =
        UNIFIED_CACHE_BLOCK_SIZE_IN_BITS + CPU_ADDR_LEN_IN_BITS + UNIFIED_CACHE_BLOCK_SIZE_IN_BITS / 8 +
        PACKET_TYPE_LEN + PACKET_PORT_LEN + 2;

    localparam int DEFAULT_MEM_DEPTH = 64;
    localparam int DEFAULT_MEM_DELAY = 100;

    typedef enum logic [1:0] {
        SIM_MEM_STATE_IDLE   = 2'd0,
        SIM_MEM_STATE_DELAY  = 2'd1,
        SIM_MEM_STATE_ACCESS = 2'd2,
        SIM_MEM_STATE_RETURN = 2'd3
    } sim_mem_state_t;

endpackage

// File: rtl/sim_memory_controller_fifo.sv
// In-order request queue; head visible combinationally, registered count/full/empty.
// Push is ignored while full and pop while empty; simultaneous push+pop leaves count unchanged.
module sim_memory_controller_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign push   = wr_vld && !full;
    assign pop    = rd_vld && !empty;
    assign rd_dat = storage[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (push) begin
            storage[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sim_memory_controller.sv
// Behavioural main memory on the cache packet channels; read return valid MEM_DELAY+2 edges after capture.
// Requests queue in order; a full queue stalls capture, a return is held until acked.
module sim_memory_controller
    import sim_memory_controller_pkg::*;
#(
    parameter int PACKET_WIDTH       = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
    parameter int BLOCK_SIZE_IN_BITS = UNIFIED_CACHE_BLOCK_SIZE_IN_BITS,
    parameter int MEM_DEPTH          = DEFAULT_MEM_DEPTH,
    parameter int MEM_DELAY          = DEFAULT_MEM_DELAY,
    parameter int QUEUE_DEPTH        = 4
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    input  logic [PACKET_WIDTH-1:0]       to_mem_packet_in,
    output logic                          to_mem_packet_ack_out,
    output logic [PACKET_WIDTH-1:0]       from_mem_packet_out,
    input  logic                          from_mem_packet_ack_in,
    output logic [$clog2(QUEUE_DEPTH):0]  pending_count_out,
    output logic                          busy_out,
    output logic                          error_out
);
    localparam int MASK_LEN   = BLOCK_SIZE_IN_BITS / 8;
    localparam int OFFSET_LEN = $clog2(MASK_LEN);
    localparam int ADDR_LO    = BLOCK_SIZE_IN_BITS;
    localparam int MASK_LO    = ADDR_LO + CPU_ADDR_LEN_IN_BITS;
    localparam int VALID_POS  = PACKET_WIDTH - 1;
    localparam int Q_WIDTH    = PACKET_WIDTH - 1;
    localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W      = $clog2(MEM_DELAY + 1);

    sim_mem_state_t state;
    sim_mem_state_t next_state;
    logic [CNT_W-1:0] delay_cnt;
    logic [CNT_W-1:0] next_delay_cnt;

    logic                            capture;
    logic                            pop;
    logic                            q_full;
    logic                            q_empty;
    logic [Q_WIDTH-1:0]              head;
    logic                            head_is_write;
    logic [CPU_ADDR_LEN_IN_BITS-1:0] head_addr;
    logic [31:0]                     blk_idx;
    logic                            in_range;
    logic [BLOCK_SIZE_IN_BITS-1:0]   mem_array [MEM_DEPTH];
    logic [BLOCK_SIZE_IN_BITS-1:0]   cur_block;
    logic [BLOCK_SIZE_IN_BITS-1:0]   mask_ext;
    logic [BLOCK_SIZE_IN_BITS-1:0]   merged_block;

    // The ack cycle blanks the input so a requester still holding the packet is not captured twice
    assign capture = to_mem_packet_in[VALID_POS] && !q_full && !to_mem_packet_ack_out;

    // The valid bit is implied by queue occupancy, so only the remaining fields are stored
    sim_memory_controller_fifo #(
        .WIDTH (Q_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_request_fifo (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .wr_vld   (capture),
        .wr_dat   (to_mem_packet_in[Q_WIDTH-1:0]),
        .rd_vld   (pop),
        .rd_dat   (head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (pending_count_out)
    );

    assign head_is_write = head[Q_WIDTH-1];
    assign head_addr     = head[MASK_LO-1:ADDR_LO];
    assign blk_idx       = 32'(head_addr >> OFFSET_LEN);
    assign in_range      = (blk_idx < 32'(MEM_DEPTH));
    assign cur_block     = in_range ? mem_array[blk_idx[IDX_W-1:0]] : '0;

    always_comb begin
        mask_ext = '0;
        for (int b = 0; b < MASK_LEN; b++) begin
            mask_ext[b*8 +: 8] = {8{head[MASK_LO + b]}};
        end
    end

    assign merged_block = (cur_block & ~mask_ext) | (head[BLOCK_SIZE_IN_BITS-1:0] & mask_ext);
    assign busy_out     = (state != SIM_MEM_STATE_IDLE) || !q_empty;

    always_comb begin
        next_state     = state;
        next_delay_cnt = delay_cnt;
        pop            = 1'b0;
        case (state)
            SIM_MEM_STATE_IDLE: begin
                next_delay_cnt = '0;
                if (!q_empty) next_state = SIM_MEM_STATE_DELAY;
            end
            SIM_MEM_STATE_DELAY: begin
                if (delay_cnt == CNT_W'(MEM_DELAY - 1)) begin
                    next_state = SIM_MEM_STATE_ACCESS;
                end else begin
                    next_delay_cnt = delay_cnt + CNT_W'(1);
                end
            end
            SIM_MEM_STATE_ACCESS: begin
                pop            = 1'b1;
                next_delay_cnt = '0;
                next_state     = head_is_write ? SIM_MEM_STATE_IDLE : SIM_MEM_STATE_RETURN;
            end
            SIM_MEM_STATE_RETURN: begin
                if (from_mem_packet_ack_in) next_state = SIM_MEM_STATE_IDLE;
            end
            default: next_state = SIM_MEM_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state                 <= SIM_MEM_STATE_IDLE;
            delay_cnt             <= '0;
            to_mem_packet_ack_out <= 1'b0;
            from_mem_packet_out   <= '0;
            error_out             <= 1'b0;
        end else begin
            state                 <= next_state;
            delay_cnt             <= next_delay_cnt;
            to_mem_packet_ack_out <= capture;
            if (pop && !in_range) begin
                error_out <= 1'b1;
            end
            if (pop && !head_is_write) begin
                from_mem_packet_out <= {1'b1, 1'b0, head[Q_WIDTH-2:BLOCK_SIZE_IN_BITS], cur_block};
            end else if (state == SIM_MEM_STATE_RETURN && from_mem_packet_ack_in) begin
                from_mem_packet_out <= '0;
            end
        end
    end

    // Backing store survives reset; out-of-range writes are dropped
    always_ff @(posedge clk_in) begin
        if (pop && head_is_write && in_range) begin
            mem_array[blk_idx[IDX_W-1:0]] <= merged_block;
        end
    end

endmodule

// File: tb/tb_sim_memory_controller.sv
// Directed bench for sim_memory_controller: table of write/read vectors plus queue, range and reset sequences.
module tb_sim_memory_controller;
    localparam int BW    = 64;
    localparam int PW    = 110;
    localparam int DLY   = 10;
    localparam int QD    = 4;
    localparam int DEPTH = 64;
    localparam int NV    = 10;

    logic          clk_in = 1'b0;
    logic          reset_in = 1'b1;
    logic [PW-1:0] to_mem_packet_in = '0;
    logic          to_mem_packet_ack_out;
    logic [PW-1:0] from_mem_packet_out;
    logic          from_mem_packet_ack_in = 1'b0;
    logic [2:0]    pending_count_out;
    logic          busy_out;
    logic          error_out;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    sim_memory_controller #(
        .PACKET_WIDTH       (PW),
        .BLOCK_SIZE_IN_BITS (BW),
        .MEM_DEPTH          (DEPTH),
        .MEM_DELAY          (DLY),
        .QUEUE_DEPTH        (QD)
    ) dut (
        .clk_in                 (clk_in),
        .reset_in               (reset_in),
        .to_mem_packet_in       (to_mem_packet_in),
        .to_mem_packet_ack_out  (to_mem_packet_ack_out),
        .from_mem_packet_out    (from_mem_packet_out),
        .from_mem_packet_ack_in (from_mem_packet_ack_in),
        .pending_count_out      (pending_count_out),
        .busy_out               (busy_out),
        .error_out              (error_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        int          blk;
        logic [63:0] data;
        logic [7:0]  mask;
        logic [63:0] exp;
    } vec_t;

    function automatic logic [31:0] baddr(input int blk);
        return 32'(blk) << 3;
    endfunction

    function automatic logic [PW-1:0] mk_req(input logic wr, input logic [1:0] port, input logic [1:0] typ,
                                             input logic [7:0] mask, input int blk, input logic [63:0] data);
        return {1'b1, wr, port, typ, mask, baddr(blk), data};
    endfunction

    function automatic logic [PW-1:0] mk_ret(input logic [1:0] port, input logic [1:0] typ,
                                             input logic [7:0] mask, input int blk, input logic [63:0] data);
        return {1'b1, 1'b0, port, typ, mask, baddr(blk), data};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [PW-1:0] pkt, output int cap_cyc);
        bit got;
        got = 1'b0;
        cap_cyc = -1;
        to_mem_packet_in = pkt;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk_in);
            if (to_mem_packet_ack_out) begin
                got = 1'b1;
                cap_cyc = cyc;
            end
        end
        to_mem_packet_in = '0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_ack: no ack within 60 cycles");
        end
    endtask

    task automatic wait_return(output logic [PW-1:0] pkt, output int ret_cyc);
        ret_cyc = -1;
        pkt = '0;
        for (int i = 0; i < 200 && ret_cyc < 0; i++) begin
            if (from_mem_packet_out[PW-1]) begin
                pkt = from_mem_packet_out;
                ret_cyc = cyc;
            end else begin
                @(negedge clk_in);
            end
        end
        if (ret_cyc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_return: no return within 200 cycles");
        end
    endtask

    task automatic ack_return(input string name);
        from_mem_packet_ack_in = 1'b1;
        @(negedge clk_in);
        from_mem_packet_ack_in = 1'b0;
        check({name, "_clear"}, from_mem_packet_out, '0);
    endtask

    task automatic wait_idle(input string name);
        bit saw_ret;
        bit done;
        saw_ret = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk_in);
            if (from_mem_packet_out[PW-1]) saw_ret = 1'b1;
            if (!busy_out) done = 1'b1;
        end
        check({name, "_idle"}, done, 1);
        check({name, "_noret"}, saw_ret, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t          vecs[NV];
        logic [PW-1:0] rp;
        logic [PW-1:0] req;
        int            t_cap;
        int            t_ret;
        bit            stable;
        int            acks[5];
        logic [63:0]   ret_data[5];
        int            nret;
        int            nsent;
        int            peak;
        bit            saw_ret;

        vecs[0] = '{1'b1, 3,  64'hA5A5A5A5A5A5A5A5, 8'hFF, 64'h0};
        vecs[1] = '{1'b0, 3,  64'h5555555555555555, 8'h3C, 64'hA5A5A5A5A5A5A5A5};
        vecs[2] = '{1'b1, 5,  64'h1111111111111111, 8'hFF, 64'h0};
        vecs[3] = '{1'b1, 5,  64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'h0};
        vecs[4] = '{1'b0, 5,  64'h5555555555555555, 8'h3C, 64'h11111111FFFFFFFF};
        vecs[5] = '{1'b1, 7,  64'h0123456789ABCDEF, 8'hFF, 64'h0};
        vecs[6] = '{1'b1, 7,  64'hFFEEDDCCBBAA9988, 8'hA5, 64'h0};
        vecs[7] = '{1'b0, 7,  64'h5555555555555555, 8'h3C, 64'hFF23DD6789AACD88};
        vecs[8] = '{1'b1, 63, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0};
        vecs[9] = '{1'b0, 63, 64'h5555555555555555, 8'h3C, 64'hDEADBEEFCAFEF00D};

        repeat (3) @(negedge clk_in);
        check("rst_ack", to_mem_packet_ack_out, 0);
        check("rst_ret", from_mem_packet_out, '0);
        check("rst_pending", pending_count_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_error", error_out, 0);
        reset_in = 1'b0;
        @(negedge clk_in);

        // Table: preload, partial-mask merges and read-backs
        for (int i = 0; i < NV; i++) begin
            req = mk_req(vecs[i].wr, 2'(i), 2'(i + 1), vecs[i].mask, vecs[i].blk, vecs[i].data);
            send(req, t_cap);
            if (vecs[i].wr) begin
                wait_idle($sformatf("vec%0d_wr", i));
            end else begin
                wait_return(rp, t_ret);
                check($sformatf("vec%0d_rd", i), rp,
                      mk_ret(2'(i), 2'(i + 1), vecs[i].mask, vecs[i].blk, vecs[i].exp));
                ack_return($sformatf("vec%0d", i));
            end
        end
        check("no_error_in_range", error_out, 0);

        // Latency and hold-until-ack
        send(mk_req(1'b0, 2'd2, 2'd1, 8'h00, 3, 64'h0), t_cap);
        wait_return(rp, t_ret);
        check("read_latency", t_ret - t_cap, DLY + 2);
        check("read_data", rp, mk_ret(2'd2, 2'd1, 8'h00, 3, 64'hA5A5A5A5A5A5A5A5));
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            if (from_mem_packet_out !== rp) stable = 1'b0;
        end
        check("ret_hold_stable", stable, 1);
        ack_return("hold");
        check("idle_after_ack", busy_out, 0);

        // Queue: five back-to-back reads into a four-entry queue
        for (int k = 0; k < 5; k++) begin
            send(mk_req(1'b1, 2'd0, 2'd0, 8'hFF, 10 + k, 64'h1000000000000000 + 64'(k)), t_cap);
            wait_idle($sformatf("qpre%0d", k));
        end
        for (int k = 0; k < 5; k++) begin
            acks[k] = -1;
            ret_data[k] = '0;
        end
        nret = 0;
        nsent = 0;
        peak = 0;
        to_mem_packet_in = mk_req(1'b0, 2'd1, 2'd2, 8'h00, 10, 64'h0);
        for (int c = 0; c < 400 && nret < 5; c++) begin
            @(negedge clk_in);
            from_mem_packet_ack_in = 1'b0;
            if (int'(pending_count_out) > peak) peak = int'(pending_count_out);
            if (to_mem_packet_ack_out) begin
                if (nsent < 5) acks[nsent] = cyc;
                nsent++;
                to_mem_packet_in = (nsent < 5) ? mk_req(1'b0, 2'd1, 2'd2, 8'h00, 10 + nsent, 64'h0) : '0;
            end
            if (from_mem_packet_out[PW-1]) begin
                if (nret < 5) ret_data[nret] = from_mem_packet_out[63:0];
                nret++;
                from_mem_packet_ack_in = 1'b1;
            end
        end
        to_mem_packet_in = '0;
        @(negedge clk_in);
        from_mem_packet_ack_in = 1'b0;
        check("q_returns", nret, 5);
        check("q_acks", nsent, 5);
        for (int k = 1; k < 4; k++) begin
            check($sformatf("q_ack_gap%0d", k), acks[k] - acks[k-1], 2);
        end
        check("q_fifth_ack", acks[4] - acks[0], DLY + 3);
        check("q_peak", peak, QD);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("q_order%0d", k), ret_data[k], 64'h1000000000000000 + 64'(k));
        end

        // Out of range: block 64 read, block 67 write must not alias block 3
        send(mk_req(1'b0, 2'd3, 2'd3, 8'hFF, 64, 64'h0), t_cap);
        wait_return(rp, t_ret);
        check("oor_read", rp, mk_ret(2'd3, 2'd3, 8'hFF, 64, 64'h0));
        check("oor_error", error_out, 1);
        ack_return("oor");
        send(mk_req(1'b1, 2'd0, 2'd0, 8'hFF, 67, 64'h0), t_cap);
        wait_idle("oor_wr");
        send(mk_req(1'b0, 2'd1, 2'd0, 8'h00, 3, 64'h0), t_cap);
        wait_return(rp, t_ret);
        check("oor_no_alias", rp, mk_ret(2'd1, 2'd0, 8'h00, 3, 64'hA5A5A5A5A5A5A5A5));
        check("oor_error_sticky", error_out, 1);
        ack_return("oor_after");

        // Reset mid-service with one more read queued
        send(mk_req(1'b0, 2'd0, 2'd0, 8'h00, 7, 64'h0), t_cap);
        send(mk_req(1'b0, 2'd0, 2'd0, 8'h00, 5, 64'h0), t_ret);
        repeat (3) @(negedge clk_in);
        reset_in = 1'b1;
        #1;
        check("rst_mid_outputs", {to_mem_packet_ack_out, from_mem_packet_out, pending_count_out, busy_out, error_out}, '0);
        @(negedge clk_in);
        reset_in = 1'b0;
        saw_ret = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            if (from_mem_packet_out[PW-1]) saw_ret = 1'b1;
        end
        check("rst_no_return", saw_ret, 0);
        check("rst_pending_after", pending_count_out, 0);
        send(mk_req(1'b0, 2'd2, 2'd2, 8'h00, 7, 64'h0), t_cap);
        wait_return(rp, t_ret);
        check("rst_mem_intact", rp, mk_ret(2'd2, 2'd2, 8'h00, 7, 64'hFF23DD6789AACD88));
        ack_return("rst_after");

        // Write immediately followed by read of the same block
        send(mk_req(1'b1, 2'd0, 2'd0, 8'hFF, 20, 64'hCAFEBABE87654321), t_cap);
        send(mk_req(1'b0, 2'd3, 2'd1, 8'h00, 20, 64'h0), t_cap);
        wait_return(rp, t_ret);
        check("raw_order", rp, mk_ret(2'd3, 2'd1, 8'h00, 20, 64'hCAFEBABE87654321));
        ack_return("raw");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sim_memory_controller.md
Name: sim_memory_controller

Overview:
Parametrised behavioural main-memory model that sits on the unified cache's to-mem/from-mem packet channels in unit and integration benches. It replaces ad-hoc per-bench memory FSMs with one reusable block. Improvements over those FSMs:
- queues multiple outstanding requests in order;
- merges partial writes by byte mask instead of overwriting;
- flags out-of-range accesses;
- exposes occupancy for bench checks.

Parameters:
PACKET_WIDTH, `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, width of request/return packets (field positions from shared packet macros)
BLOCK_SIZE_IN_BITS, `UNIFIED_CACHE_BLOCK_SIZE_IN_BITS, data field width; byte-mask length = BLOCK_SIZE_IN_BITS/8
MEM_DEPTH, 64, number of blocks in the backing array; block index = addr >> `UNIFIED_CACHE_BLOCK_OFFSET_LEN_IN_BITS
MEM_DELAY, 100, access latency in cycles; must be >= 1
QUEUE_DEPTH, 4, request queue entries; power of two, >= 2

Ports:
clk_in  input  1  clock
reset_in  input  1  reset
to_mem_packet_in  input  PACKET_WIDTH  request from cache; valid/is_write/addr/data/byte_mask/type/port fields
to_mem_packet_ack_out  output  1  one-cycle pulse: request captured
from_mem_packet_out  output  PACKET_WIDTH  read return packet, held until acked
from_mem_packet_ack_in  input  1  cache accepted return packet
pending_count_out  output  $clog2(QUEUE_DEPTH)+1  queued requests, including the one in service
busy_out  output  1  FSM not IDLE or queue non-empty
error_out  output  1  sticky out-of-range flag

Behaviour:
- Reset: reset_in asynchronous, active-high; clock clk_in.
  - At reset, all outputs go to 0, the queue empties, and the FSM enters IDLE.
  - The memory array is not cleared.
  - Reset mid-operation discards all queued and in-service requests; no return is produced for them.
- Capture rule:
  - A request is captured at an edge where packet valid=1, the queue is not full, and to_mem_packet_ack_out=0.
  - to_mem_packet_ack_out is 1 for exactly the following cycle. Input is ignored during that cycle, so a held packet is never captured twice.
  - When the queue is full, the requester holds the packet; capture happens on the first edge after an entry pops.
- Writes are acknowledged at capture and need no return packet. Reads return via from_mem_packet_out.
- Service is strictly in order, so read-after-write to the same address returns the written data.
- FSM states:
  - IDLE: go to DELAY when the queue is non-empty; counter=0.
  - DELAY: counter increments each edge; at counter==MEM_DELAY-1, go to ACCESS.
  - ACCESS: act on the queue head and pop it.
    - Write: mem[idx] = (mem[idx] & ~mask_ext) | (data & mask_ext), where mask_ext is each mask bit replicated over 8 bits. Then go to IDLE.
    - Read: register the return packet (valid=1, data=mem[idx], other fields copied from the request, is_write=0) and go to RETURN.
  - RETURN: hold from_mem_packet_out stable. At an edge with from_mem_packet_ack_in=1, clear from_mem_packet_out to 0 and go to IDLE.
- Latency: a read captured at edge T shows return valid after edge T+MEM_DELAY+2.
  - Each subsequent queued request adds one bubble cycle (IDLE) plus MEM_DELAY+1.
- Out of range (idx >= MEM_DEPTH):
  - write: dropped;
  - read: returns data 0;
  - both: set error_out, which holds until reset.
- Simultaneous capture and pop in one edge: count unchanged, and the full condition is evaluated before the pop.
- Queue pointers wrap modulo QUEUE_DEPTH.
- pending_count_out is registered and updated on the same edge as capture/pop.

Decomposition:
- Shared header (parameters.h):
  - packet field position macros (existing);
  - FSM state encodings (SIM_MEM_STATE_IDLE/DELAY/ACCESS/RETURN);
  - default MEM_DELAY/MEM_DEPTH.
- Sub-module: mem_request_fifo, a synchronous FIFO with parametrised width and depth and full/empty/count outputs.
- Top module: FSM, latency counter, mask merge, and array.

Test Plan:
1. Preload mem[3]=0xA5 pattern; send read at addr 3<<offset; return ack held low for 5 cycles.
   -> return valid at T+MEM_DELAY+2 with data=pattern; packet stays stable for 5 cycles; cleared one cycle after ack.
2. Preload mem[5]=all 0x11; write data all 0xFF with byte_mask 0x0F; then read addr 5.
   -> low 4 bytes 0xFF, remaining bytes 0x11; no return packet for the write.
3. With QUEUE_DEPTH=4 and MEM_DELAY=10, issue 5 back-to-back reads.
   -> 4 ack pulses, each separated by one ignored cycle.
   -> 5th acked only after the first pop; pending_count_out peaks at 4.
   -> returns arrive in issue order.
4. Read at block index 64 (MEM_DEPTH=64).
   -> return data 0; error_out=1 and stays 1. A following valid access still succeeds.
5. Capture a read, then assert reset_in at T+50.
   -> outputs 0 immediately; no return after reset release.
   -> a new read after release returns correctly; previously written memory is intact.
6. Write then read the same address back-to-back.
   -> read returns the new data, confirming ordering.
